// File: rtl/cell_seed_loader.sv
// cell_seed_loader
//   Streams one seed pattern into a P_PARAM_N x P_PARAM_M cell RAM, one cell
//   per accepted write, in raster order (address = row*P_PARAM_N + col).
//
// Ports
//   clk       : system clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   start     : request a pass (accepted in IDLE or DONE, ignored in FILL)
//   mode      : 00 clear, 01 random, 10 glider, 11 clear
//   seed      : LFSR seed, latched with start (0 is replaced by 16'hACE1)
//   density   : random-mode live threshold, latched with start
//   wr_ready  : arbiter accepts the write presented this cycle
//   wr_en     : write request (registered)
//   wr_addr   : linear cell address (registered)
//   wr_data   : cell value, decoded from registered state only
//   busy      : a pass is in progress (registered)
//   done      : the last pass completed (registered)
module cell_seed_loader #(
  parameter int P_PARAM_N = 400,
  parameter int P_PARAM_M = 300,
  parameter int ADDR_W    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [15:0]       seed,
  input  logic [3:0]        density,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (P_PARAM_N > 1) ? $clog2(P_PARAM_N) : 1;
  localparam int ROW_W = (P_PARAM_M > 1) ? $clog2(P_PARAM_M) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(P_PARAM_N - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(P_PARAM_N * P_PARAM_M - 1);
  localparam logic [15:0]       LFSR_INIT = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [ROW_W-1:0]  row_q,     row_d;
  logic [COL_W-1:0]  col_q,     col_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [15:0]       lfsr_q,    lfsr_d;
  logic [1:0]        mode_q,    mode_d;
  logic [3:0]        density_q, density_d;
  logic              wr_en_q,   wr_en_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic [15:0]       lfsr_next;
  logic              glider_cell;

  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    lfsr_d    = lfsr_q;
    mode_d    = mode_q;
    density_d = density_q;
    wr_en_d   = wr_en_q;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_FILL;
          row_d     = '0;
          col_d     = '0;
          addr_d    = '0;
          lfsr_d    = (seed == 16'h0000) ? LFSR_INIT : seed;
          mode_d    = mode;
          density_d = density;
          wr_en_d   = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      ST_FILL: begin
        // Everything holds while the arbiter stalls us.
        if (wr_ready) begin
          lfsr_d = lfsr_next;
          if (addr_q == ADDR_LAST) begin
            state_d = ST_DONE;
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Address is a running counter kept alongside row/col so no
            // row*N product is ever needed.
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      lfsr_q    <= LFSR_INIT;
      mode_q    <= 2'b00;
      density_q <= 4'd0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      lfsr_q    <= lfsr_d;
      mode_q    <= mode_d;
      density_q <= density_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Glider occupies the top-left 3x3 corner of the grid.
  always_comb begin
    glider_cell = 1'b0;
    if (row_q == ROW_W'(0) && col_q == COL_W'(1)) glider_cell = 1'b1;
    if (row_q == ROW_W'(1) && col_q == COL_W'(2)) glider_cell = 1'b1;
    if (row_q == ROW_W'(2) && col_q <= COL_W'(2)) glider_cell = 1'b1;
  end

  // Data is decoded from the registered position/LFSR, so it always matches
  // the address being presented. Forced low when no write is requested.
  always_comb begin
    wr_data = 1'b0;
    if (wr_en_q) begin
      case (mode_q)
        2'b01:   wr_data = (lfsr_q[3:0] < density_q);
        2'b10:   wr_data = glider_cell;
        default: wr_data = 1'b0;
      endcase
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_cell_seed_loader.sv
// Directed bench for cell_seed_loader on a reduced 10x8 grid (80 cells) so
// that every pass covers the full grid in a few hundred cycles.
module tb_cell_seed_loader;

  localparam int N      = 10;
  localparam int M      = 8;
  localparam int AW     = 8;
  localparam int CELLS  = N * M;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [15:0]   seed = 16'h0000;
  logic [3:0]    density = 4'd0;
  logic          wr_ready = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  cell_seed_loader #(
    .P_PARAM_N (N),
    .P_PARAM_M (M),
    .ADDR_W    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .seed     (seed),
    .density  (density),
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Glider cells by linear address: (0,1) (1,2) (2,0) (2,1) (2,2).
  function automatic logic glider_at(input int a);
    return (a == 1) || (a == N + 2) || (a == 2 * N) || (a == 2 * N + 1) || (a == 2 * N + 2);
  endfunction

  // Runs one full pass and checks every presented write against the model.
  task automatic run_pass(input string name, input logic [1:0] md, input logic [15:0] sd,
                          input logic [3:0] dens, input bit stall, input bit hold_start,
                          output int live_cnt);
    int          exp_addr;
    int          cycles;
    int          bad;
    logic [15:0] lf;
    logic        exp_d;
    logic        rdy;
    mode = md; seed = sd; density = dens; start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    mode = 2'b11; seed = 16'hFFFF; density = 4'hF;   // latched values must be used
    exp_addr = 0; cycles = 0; bad = 0; live_cnt = 0;
    lf = (sd == 16'h0000) ? 16'hACE1 : sd;
    chk({name, " first_addr"}, 32'(wr_addr), 32'd0);
    while (exp_addr < CELLS && cycles < 4 * CELLS) begin
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_ready = rdy;
      case (md)
        2'b01:   exp_d = (lf[3:0] < dens);
        2'b10:   exp_d = glider_at(exp_addr);
        default: exp_d = 1'b0;
      endcase
      if (wr_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          32'(wr_addr) !== 32'(exp_addr) || wr_data !== exp_d) begin
        bad++;
        if (bad <= 4)
          $display("FAIL %s write addr=%0d: en=%b busy=%b done=%b data=%b exp_data=%b",
                   name, exp_addr, wr_en, busy, done, wr_data, exp_d);
      end
      tick();
      if (rdy) begin
        if (exp_d) live_cnt++;
        exp_addr++;
        lf = lfsr_step(lf);
      end
      cycles++;
    end
    wr_ready = 1'b1;
    chk({name, " stream_errors"}, 32'(bad), 32'd0);
    chk({name, " all_cells_sent"}, 32'(exp_addr), 32'(CELLS));
    if (!stall) chk({name, " pass_cycles"}, 32'(cycles), 32'(CELLS));
    chk({name, " end_wr_en"}, 32'(wr_en), 32'd0);
    chk({name, " end_busy"},  32'(busy),  32'd0);
    chk({name, " end_done"},  32'(done),  32'd1);
    $display("pass %s mode=%b seed=%h density=%0d cycles=%0d live=%0d",
             name, md, sd, dens, cycles, live_cnt);
  endtask

  initial begin
    int live;

    // Reset state
    tick(); tick();
    chk("rst wr_en",   32'(wr_en),   32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst wr_data", 32'(wr_data), 32'd0);
    chk("rst busy",    32'(busy),    32'd0);
    chk("rst done",    32'(done),    32'd0);

    // Reset wins over start on the same edge
    start = 1'b1; mode = 2'b01; density = 4'hF;
    tick();
    chk("rst_prio wr_en", 32'(wr_en), 32'd0);
    chk("rst_prio busy",  32'(busy),  32'd0);
    start = 1'b0; rst = 1'b0;
    tick();
    chk("idle wr_en", 32'(wr_en), 32'd0);

    // Clear pass, full throughput
    run_pass("clear", 2'b00, 16'h0000, 4'd0, 1'b0, 1'b0, live);
    chk("clear live", 32'(live), 32'd0);

    // done persists in DONE without start
    tick(); tick(); tick();
    chk("done_hold done",  32'(done),  32'd1);
    chk("done_hold wr_en", 32'(wr_en), 32'd0);

    // Glider: five live writes at 1, N+2, 2N, 2N+1, 2N+2
    run_pass("glider", 2'b10, 16'h0000, 4'd0, 1'b0, 1'b0, live);
    chk("glider live", 32'(live), 32'd5);

    // Random, seed 0 replaced by ACE1, density 8
    run_pass("rand_d8", 2'b01, 16'h0000, 4'd8, 1'b0, 1'b0, live);
    // Density boundaries and explicit seed
    run_pass("rand_d0", 2'b01, 16'h1234, 4'd0, 1'b0, 1'b0, live);
    chk("rand_d0 live", 32'(live), 32'd0);
    run_pass("rand_d15", 2'b01, 16'hBEEF, 4'd15, 1'b0, 1'b0, live);
    // LFSR must hold during stalls
    run_pass("rand_stall", 2'b01, 16'h5A5A, 4'd5, 1'b1, 1'b0, live);
    // Clear with stalls, and mode 11 behaves as clear
    run_pass("clear_stall", 2'b00, 16'h0000, 4'd0, 1'b1, 1'b0, live);
    run_pass("mode11", 2'b11, 16'h0000, 4'd9, 1'b0, 1'b0, live);
    chk("mode11 live", 32'(live), 32'd0);

    // Reset mid-FILL
    mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("mid addr_before_rst", 32'(wr_addr), 32'd30);
    rst = 1'b1;
    tick();
    chk("mid_rst wr_en",   32'(wr_en),   32'd0);
    chk("mid_rst busy",    32'(busy),    32'd0);
    chk("mid_rst wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst done",    32'(done),    32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst wr_en", 32'(wr_en), 32'd0);
    run_pass("restart", 2'b10, 16'h0000, 4'd0, 1'b0, 1'b0, live);
    chk("restart live", 32'(live), 32'd5);

    // start held high: one pass only, next pass begins right after DONE
    run_pass("held_start", 2'b00, 16'h0000, 4'd0, 1'b0, 1'b1, live);
    tick();
    chk("held_start re_wr_en", 32'(wr_en),   32'd1);
    chk("held_start re_addr",  32'(wr_addr), 32'd0);
    chk("held_start re_done",  32'(done),    32'd0);
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
